audio_adc_deserializer: RTL and testbench
=========================================

Name: audio_adc_deserializer

Overview:
Front-end capture stage for the guitar effects chain. It receives the codec ADC's I2S serial stream (bit clock, word select, data), oversampled on the system clock, and deserializes each stereo frame. Each channel is sign-extended to a 32-bit signed integer sample, which directly feeds the effect stages' 32-bit integer sample input (the distortion stage's int-to-float converter). A one-cycle valid strobe marks each new stereo pair.

Parameters:
SAMPLE_WIDTH, 24, significant bits per channel word, MSB first; legal range 8..32.
SYNC_STAGES, 2, flip-flop synchronizer depth applied to bclk_in, lrclk_in and adcdat_in; minimum 2.

Ports:
clk  input  1  system clock; frequency must be at least 4x the bclk_in frequency.
reset  input  1  synchronous, active-high reset.
bclk_in  input  1  I2S bit clock from the codec, asynchronous to clk.
lrclk_in  input  1  I2S word select: 0 = left, 1 = right; asynchronous.
adcdat_in  input  1  I2S serial ADC data; asynchronous.
sample_left  output  32  last complete left sample, sign-extended.
sample_right  output  32  last complete right sample, sign-extended.
sample_valid  output  1  one-cycle pulse when both sample outputs update.
frame_error  output  1  one-cycle pulse when a channel word is cut short.

Behaviour:
- Reset: this is a synchronous, active-high reset. On clk with reset=1, all outputs go to 0, the synchronizers clear, and the FSM enters IDLE. Reset mid-word discards any partial word, and no valid or error pulse is emitted for it.
- Synchronization: all three inputs pass through SYNC_STAGES flops, at equal depth so they stay aligned. A bclk rising edge is detected as synced bclk=1 while the previous synced value was 0. All FSM activity happens only on cycles with a detected rising edge ("bit tick").
- On each bit tick, synced lrclk and adcdat are sampled. lr_prev holds the lrclk value from the previous bit tick.
- Word boundary: lrclk at the current tick differs from lr_prev. Per I2S, this tick is the one-bit delay slot and its data bit is ignored.
- FSM states:
  - IDLE: ignore ticks until the first word boundary, then go to SHIFT. The channel is the new lrclk value. Any partial first word after reset is discarded.
  - SHIFT: shift adcdat into the shift register MSB-first and increment bit_cnt. When bit_cnt reaches SAMPLE_WIDTH, latch the word into that channel's holding register and go to WAIT.
  - WAIT: ignore trailing pad bits until the next word boundary, then go to SHIFT with bit_cnt=0 and the channel taken from lrclk.
- Boundary in SHIFT with bit_cnt < SAMPLE_WIDTH (short word):
  - frame_error pulses for 1 clk.
  - The partial word is discarded and the holding register is unchanged.
  - The FSM restarts SHIFT for the new channel.
  - If the short word was the right channel, no sample_valid is produced for that frame.
- Output update:
  - When a right-channel word completes, sample_left and sample_right are loaded on the following clk edge from the left holding register and the completed right word. sample_valid is 1 for that single cycle.
  - Completion of a left word alone changes no output.
  - The first frame after reset outputs only after both a left and a right word have completed since reset; a right-only completion is suppressed.
- Sign extension: out[31:SAMPLE_WIDTH] = word[SAMPLE_WIDTH-1]. When SAMPLE_WIDTH=32 the word passes through unchanged.
- Outputs hold their values between valid pulses.
- Latency: sample_valid rises SYNC_STAGES+2 clk cycles after the raw bclk_in rising edge that carries the right word's LSB.
- Simultaneous events: a word boundary and completion cannot coincide in one tick; a boundary tick always takes the boundary path.
- frame_error and sample_valid are never asserted in the same cycle.

Test Plan:
- Reset check: hold reset 5 cycles with inputs toggling -> all outputs 0. sample_valid stays 0 until the first full stereo frame.
- Basic capture: 64-bclk I2S frames (clk = 8x bclk), left=0x7FFFFF, right=0x800000 -> sample_left=0x007FFFFF, sample_right=0xFF800000. Exactly one sample_valid pulse per frame, at SYNC_STAGES+2 cycles after the right LSB edge.
- Stream of 4 frames with left=0x000001/0x123456/0xFFFFFF/0x400000 and right = bitwise inverse -> four valid pulses with matching sign-extended values. Outputs are stable between pulses.
- Start mid-word: release reset halfway through a left word -> that partial word is ignored. The first valid comes after the next complete left+right pair.
- Short word: right channel truncated to 12 bclks -> one frame_error pulse, no sample_valid for that frame, outputs keep the previous values. The next normal frame captures correctly.
- Reset mid-word: assert reset after 10 right-channel bits -> outputs 0, no valid or error pulse. Capture resumes correctly after the next word boundary.

Source files
------------

// File: rtl/audio_adc_deserializer.sv
// audio_adc_deserializer: I2S ADC capture, synchronized and sign-extended to 32-bit stereo samples
module audio_adc_deserializer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bclk_in,
  input  logic        lrclk_in,
  input  logic        adcdat_in,
  output logic [31:0] sample_left,
  output logic [31:0] sample_right,
  output logic        sample_valid,
  output logic        frame_error
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int S = SYNC_STAGES;
  localparam int CW = $clog2(SW + 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;
  function automatic logic [31:0] sext(input logic [SW-1:0] w);
    logic [31:0] e;
    e = {32{w[SW-1]}};
    e[SW-1:0] = w;
    return e;
  endfunction
  logic [S-1:0] bclk_sync_q, bclk_sync_d, lr_sync_q, lr_sync_d, dat_sync_q, dat_sync_d;
  logic bclk_prev_q, bclk_prev_d, seen_q, seen_d, lr_prev_q, lr_prev_d, ch_q, ch_d;
  logic have_left_q, have_left_d, upd_q, upd_d;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-2:0] shift_q, shift_d;
  logic [SW-1:0] left_hold_q, left_hold_d, right_hold_q, right_hold_d, word;
  logic [31:0] sample_left_q, sample_left_d, sample_right_q, sample_right_d;
  logic sample_valid_q, sample_valid_d, frame_error_q, frame_error_d;
  logic tick, lr, bnd, in_shift, done;
  always_comb begin
    bclk_sync_d = {bclk_sync_q[S-2:0], bclk_in};
    lr_sync_d = {lr_sync_q[S-2:0], lrclk_in};
    dat_sync_d = {dat_sync_q[S-2:0], adcdat_in};
    tick = bclk_sync_q[S-1] & ~bclk_prev_q;
    lr = lr_sync_q[S-1];
    bnd = tick & seen_q & (lr != lr_prev_q);
    word = {shift_q, dat_sync_q[S-1]};
    in_shift = state_q == S_SHIFT;
    done = tick & ~bnd & in_shift & (cnt_q == CW'(SW - 1));
    bclk_prev_d = bclk_sync_q[S-1];
    seen_d = seen_q | tick;
    lr_prev_d = tick ? lr : lr_prev_q;
    state_d = bnd ? S_SHIFT : done ? S_WAIT : state_q;
    ch_d = bnd ? lr : ch_q;
    cnt_d = bnd ? '0 : (tick & in_shift) ? cnt_q + CW'(1) : cnt_q;
    shift_d = (tick & in_shift & ~bnd) ? word[SW-2:0] : shift_q;
    left_hold_d = (done & ~ch_q) ? word : left_hold_q;
    right_hold_d = (done & ch_q) ? word : right_hold_q;
    have_left_d = have_left_q | (done & ~ch_q);
    upd_d = done & ch_q & have_left_q;
    sample_left_d = upd_q ? sext(left_hold_q) : sample_left_q;
    sample_right_d = upd_q ? sext(right_hold_q) : sample_right_q;
    sample_valid_d = upd_q;
    frame_error_d = bnd & in_shift;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lr_sync_q <= '0;
      dat_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      seen_q <= 1'b0;
      lr_prev_q <= 1'b0;
      state_q <= S_IDLE;
      ch_q <= 1'b0;
      cnt_q <= '0;
      shift_q <= '0;
      left_hold_q <= '0;
      right_hold_q <= '0;
      have_left_q <= 1'b0;
      upd_q <= 1'b0;
      sample_left_q <= '0;
      sample_right_q <= '0;
      sample_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q <= lr_sync_d;
      dat_sync_q <= dat_sync_d;
      bclk_prev_q <= bclk_prev_d;
      seen_q <= seen_d;
      lr_prev_q <= lr_prev_d;
      state_q <= state_d;
      ch_q <= ch_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      left_hold_q <= left_hold_d;
      right_hold_q <= right_hold_d;
      have_left_q <= have_left_d;
      upd_q <= upd_d;
      sample_left_q <= sample_left_d;
      sample_right_q <= sample_right_d;
      sample_valid_q <= sample_valid_d;
      frame_error_q <= frame_error_d;
    end
  end
  assign sample_left = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = sample_valid_q;
  assign frame_error = frame_error_q;
endmodule

// File: tb/tb_audio_adc_deserializer.sv
// tb_audio_adc_deserializer: scoreboard bench driving I2S frames and checking captured samples
module tb_audio_adc_deserializer;
  localparam int SW = 24;
  localparam int SYNC = 2;
  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    time t;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, bclk = 1'b0, lrclk = 1'b0, adcdat = 1'b0;
  logic [31:0] sample_left, sample_right;
  logic sample_valid, frame_error;
  int checks = 0, failures = 0, err_seen = 0, exp_err = 0;
  exp_t q[$];
  logic m_seen = 1'b0, m_lr = 1'b0, m_have = 1'b0, m_short = 1'b0;
  logic [23:0] m_left = '0;
  logic [31:0] cur_l = '0, cur_r = '0;
  audio_adc_deserializer #(.SAMPLE_WIDTH(SW), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .reset(reset),
    .bclk_in(bclk),
    .lrclk_in(lrclk),
    .adcdat_in(adcdat),
    .sample_left(sample_left),
    .sample_right(sample_right),
    .sample_valid(sample_valid),
    .frame_error(frame_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] sext(input logic [23:0] w);
    return {{8{w[23]}}, w};
  endfunction
  always @(negedge clk) begin
    if (frame_error) begin
      err_seen++;
      chk("err_excl_valid", 64'(sample_valid), 64'd0);
    end
    if (sample_valid) begin
      chk("valid_pending", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("valid_left", 64'(sample_left), 64'(e.l));
        chk("valid_right", 64'(sample_right), 64'(e.r));
        chk("valid_time", 64'($time), 64'(e.t));
        cur_l = e.l;
        cur_r = e.r;
      end
    end
  end
  task automatic send_bit(input logic l, input logic d, output time t);
    @(negedge clk);
    bclk = 1'b0;
    lrclk = l;
    adcdat = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    t = $time;
    repeat (3) @(negedge clk);
  endtask
  task automatic send_word(input logic l, input logic [23:0] w, input int nbits, input int slot);
    logic bnd, d;
    time t;
    bnd = m_seen && (l != m_lr);
    if (bnd && m_short) begin
      exp_err++;
      m_short = 1'b0;
    end
    if (bnd && nbits < SW) m_short = 1'b1;
    for (int i = 0; i < slot; i++) begin
      d = 1'b0;
      if (i >= 1 && i <= nbits) d = w[SW-i];
      send_bit(l, d, t);
      m_seen = 1'b1;
      m_lr = l;
      if (bnd && nbits == SW && i == SW) begin
        if (!l) begin
          m_left = w;
          m_have = 1'b1;
        end else if (m_have) begin
          q.push_back('{sext(m_left), sext(w), t + 10 * (SYNC + 2)});
        end
      end
    end
  endtask
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_word(1'b0, l, SW, 32);
    send_word(1'b1, r, SW, 32);
    chk("hold_left", 64'(sample_left), 64'(cur_l));
    chk("hold_right", 64'(sample_right), 64'(cur_r));
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bclk = ~bclk;
      lrclk = i[1];
      adcdat = ~adcdat;
    end
    chk("rst_left", 64'(sample_left), 64'd0);
    chk("rst_right", 64'(sample_right), 64'd0);
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_error", 64'(frame_error), 64'd0);
    m_seen = 1'b0;
    m_have = 1'b0;
    m_short = 1'b0;
    cur_l = '0;
    cur_r = '0;
    bclk = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    logic [23:0] vals [4];
    vals = '{24'h000001, 24'h123456, 24'hFFFFFF, 24'h400000};
    do_reset();
    send_word(1'b0, 24'h0, 0, 16);
    send_word(1'b1, 24'h222222, SW, 32);
    chk("right_only_suppressed", 64'(q.size()), 64'd0);
    send_frame(24'h7FFFFF, 24'h800000);
    chk("basic_left", 64'(sample_left), 64'h007FFFFF);
    chk("basic_right", 64'(sample_right), 64'hFF800000);
    for (int i = 0; i < 4; i++) send_frame(vals[i], ~vals[i]);
    send_word(1'b0, 24'hABCDEF, SW, 32);
    send_word(1'b1, 24'h135795, 11, 12);
    chk("short_hold_left", 64'(sample_left), 64'(sext(24'h400000)));
    chk("short_hold_right", 64'(sample_right), 64'(sext(24'hBFFFFF)));
    send_word(1'b0, 24'h654321, SW, 32);
    send_word(1'b1, 24'h9ABCDE, SW, 32);
    chk("err_count_short", 64'(err_seen), 64'(exp_err));
    chk("after_short_left", 64'(sample_left), 64'h00654321);
    chk("after_short_right", 64'(sample_right), 64'hFF9ABCDE);
    send_word(1'b0, 24'h111111, SW, 32);
    send_word(1'b1, 24'h222222, 10, 11);
    do_reset();
    send_word(1'b1, 24'h0, 0, 21);
    send_frame(24'h0A0B0C, 24'hF0E0D0);
    send_frame(24'h800001, 24'h7FFFFE);
    repeat (60) @(negedge clk);
    chk("pending_empty", 64'(q.size()), 64'd0);
    chk("err_count_final", 64'(err_seen), 64'(exp_err));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
